// File: rtl/vdc_pixel_tx.sv
// vdc_pixel_tx: HuC6270-style raster timing generator and pixel streamer to the VCE.
// Position is dot (within 8-dot tile), tile (within H region), line (within V region).
// Outputs are registered one dot after the position they describe.
module vdc_pixel_tx (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       pix_en,
  input  logic [4:0] hsw,
  input  logic [6:0] hds,
  input  logic [6:0] hdw,
  input  logic [6:0] hde,
  input  logic [4:0] vsw,
  input  logic [7:0] vds,
  input  logic [8:0] vdw,
  input  logic [7:0] vcr,
  input  logic [8:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [8:0] VD,
  output logic       HSYN,
  output logic       VSYN,
  output logic       line_start,
  output logic       frame_start,
  output logic       underflow
);

  typedef enum logic [1:0] {HSYNC, HBACK, HACTIVE, HFRONT} h_state_t;
  typedef enum logic [1:0] {VSYNC, VBACK, VACTIVE, VFRONT} v_state_t;

  h_state_t   h_state, h_next;
  v_state_t   v_state, v_next;
  logic [2:0] dot;
  logic [6:0] tile;
  logic [8:0] line;

  // shadow copies of the timing config, stable for a whole line / frame
  logic [4:0] hsw_s, vsw_s;
  logic [6:0] hds_s, hdw_s, hde_s;
  logic [7:0] vds_s, vcr_s;
  logic [8:0] vdw_s;

  logic [6:0] h_len;
  logic [8:0] v_len;
  logic       h_end, line_end, v_end, line_first, frame_first, active;

  // region lengths, region-end detection and next-state for both FSMs
  always_comb begin
    h_len  = {2'b0, hsw_s};
    v_len  = {4'b0, vsw_s};
    h_next = h_state;
    v_next = v_state;
    case (h_state)
      HSYNC:   h_len = {2'b0, hsw_s};
      HBACK:   h_len = hds_s;
      HACTIVE: h_len = hdw_s;
      default: h_len = hde_s;
    endcase
    case (v_state)
      VSYNC:   v_len = {4'b0, vsw_s};
      VBACK:   v_len = {1'b0, vds_s} + 9'd1;  // back porch is vds+2 lines
      VACTIVE: v_len = vdw_s;
      default: v_len = {1'b0, vcr_s};
    endcase
    h_end       = (dot == 3'd7) && (tile == h_len);
    line_end    = h_end && (h_state == HFRONT);
    v_end       = line_end && (line == v_len);
    line_first  = (h_state == HSYNC) && (tile == 7'd0) && (dot == 3'd0);
    frame_first = line_first && (v_state == VSYNC) && (line == 9'd0);
    active      = (h_state == HACTIVE) && (v_state == VACTIVE);
    if (h_end) begin
      case (h_state)
        HSYNC:   h_next = HBACK;
        HBACK:   h_next = HACTIVE;
        HACTIVE: h_next = HFRONT;
        default: h_next = HSYNC;
      endcase
    end
    if (v_end) begin
      case (v_state)
        VSYNC:   v_next = VBACK;
        VBACK:   v_next = VACTIVE;
        VACTIVE: v_next = VFRONT;
        default: v_next = VSYNC;
      endcase
    end
  end

  assign pix_ready = pix_en & active;

  // FSM state registers, advancing one dot per pix_en
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      h_state <= HSYNC;
      v_state <= VSYNC;
    end else if (pix_en) begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // dot / tile / line position counters, cleared at each region end
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      dot  <= '0;
      tile <= '0;
      line <= '0;
    end else if (pix_en) begin
      dot <= dot + 3'd1;
      if (h_end)            tile <= '0;
      else if (dot == 3'd7) tile <= tile + 7'd1;
      if (v_end)            line <= '0;
      else if (line_end)    line <= line + 9'd1;
    end
  end

  // config capture: H at the first dot of each line, V at the first dot of each frame
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      hsw_s <= '0; hds_s <= '0; hdw_s <= '0; hde_s <= '0;
      vsw_s <= '0; vds_s <= '0; vdw_s <= '0; vcr_s <= '0;
    end else if (pix_en) begin
      if (line_first) begin
        hsw_s <= hsw; hds_s <= hds; hdw_s <= hdw; hde_s <= hde;
      end
      if (frame_first) begin
        vsw_s <= vsw; vds_s <= vds; vdw_s <= vdw; vcr_s <= vcr;
      end
    end
  end

  // registered outputs; pulses drop on dots where pix_en is low, levels hold
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      VD          <= '0;
      HSYN        <= 1'b1;
      VSYN        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else if (pix_en) begin
      HSYN        <= (h_state != HSYNC);
      VSYN        <= (v_state != VSYNC);
      line_start  <= line_first;
      frame_start <= frame_first;
      VD          <= (active && pix_valid) ? pix_data : 9'd0;
      underflow   <= active && !pix_valid;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vdc_pixel_tx.sv
// tb_vdc_pixel_tx: randomized scoreboard bench for vdc_pixel_tx.
// The reference model tracks (x, y) raster position with plain arithmetic on region boundaries.
module tb_vdc_pixel_tx;

  logic       clk = 1'b0;
  logic       reset_N, pix_en, pix_valid;
  logic [4:0] hsw, vsw;
  logic [6:0] hds, hdw, hde;
  logic [7:0] vds, vcr;
  logic [8:0] vdw, pix_data, VD;
  logic       pix_ready, HSYN, VSYN, line_start, frame_start, underflow;

  vdc_pixel_tx dut (
    .clk(clk), .reset_N(reset_N), .pix_en(pix_en),
    .hsw(hsw), .hds(hds), .hdw(hdw), .hde(hde),
    .vsw(vsw), .vds(vds), .vdw(vdw), .vcr(vcr),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .VD(VD), .HSYN(HSYN), .VSYN(VSYN),
    .line_start(line_start), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] vd;
    logic hsyn, vsyn, ls, fs, uf, rdy;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  logic [8:0] pix [4096];
  int   src = 0;   // pixels the source has handed over (observed handshakes)
  int   mi  = 0;   // pixels the model says have been consumed

  // model state
  int   mx, my;
  int   mhsw, mhds, mhdw, mhde, mvsw, mvds, mvdw, mvcr;
  logic [8:0] e_vd;
  logic e_hsyn, e_vsyn, e_ls, e_fs, e_uf;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0;
    mhsw = 0; mhds = 0; mhdw = 0; mhde = 0; mvsw = 0; mvds = 0; mvdw = 0; mvcr = 0;
    e_vd = 0; e_hsyn = 1; e_vsyn = 1; e_ls = 0; e_fs = 0; e_uf = 0;
  endtask

  function automatic logic m_vact();
    int vb_end, va_end;
    vb_end = mvsw + 1 + mvds + 2;
    va_end = vb_end + mvdw + 1;
    return (my >= vb_end) && (my < va_end);
  endfunction

  task automatic model_step(input logic en, input logic valid, output exp_t e);
    int s_end, b_end, a_end, l_len, vs_end, vb_end, va_end, f_len;
    logic act;
    if (en && mx == 0) begin
      mhsw = hsw; mhds = hds; mhdw = hdw; mhde = hde;
      if (my == 0) begin mvsw = vsw; mvds = vds; mvdw = vdw; mvcr = vcr; end
    end
    s_end  = 8 * (mhsw + 1);
    b_end  = s_end + 8 * (mhds + 1);
    a_end  = b_end + 8 * (mhdw + 1);
    l_len  = a_end + 8 * (mhde + 1);
    vs_end = mvsw + 1;
    vb_end = vs_end + mvds + 2;
    va_end = vb_end + mvdw + 1;
    f_len  = va_end + mvcr + 1;
    act = (mx >= b_end) && (mx < a_end) && (my >= vb_end) && (my < va_end);
    if (en) begin
      e_hsyn = !(mx < s_end);
      e_vsyn = !(my < vs_end);
      e_ls   = (mx == 0);
      e_fs   = (mx == 0) && (my == 0);
      e_uf   = act && !valid;
      if (act && valid) begin e_vd = pix[mi % 4096]; mi++; end
      else e_vd = 0;
      mx++;
      if (mx == l_len) begin
        mx = 0; my++;
        if (my == f_len) my = 0;
      end
    end else begin
      e_ls = 0; e_fs = 0; e_uf = 0;
    end
    e.vd = e_vd; e.hsyn = e_hsyn; e.vsyn = e_vsyn;
    e.ls = e_ls; e.fs = e_fs; e.uf = e_uf; e.rdy = en && act;
  endtask

  // drive one clk of stimulus, queue its expected outcome, and advance the source on handshake
  task automatic step(input logic en, input logic valid);
    exp_t e;
    @(negedge clk);
    pix_en = en; pix_valid = valid; pix_data = pix[src % 4096];
    model_step(en, valid, e);
    sb.push_back(e);
    #1;
    if (pix_ready && pix_valid) src++;
  endtask

  // monitor: sample pix_ready before the edge, registered outputs after it
  initial begin
    exp_t e;
    logic rdy_s;
    forever begin
      @(negedge clk); #1;
      rdy_s = pix_ready;
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pix_ready",   16'(rdy_s),       16'(e.rdy));
        chk("VD",          16'(VD),          16'(e.vd));
        chk("HSYN",        16'(HSYN),        16'(e.hsyn));
        chk("VSYN",        16'(VSYN),        16'(e.vsyn));
        chk("line_start",  16'(line_start),  16'(e.ls));
        chk("frame_start", 16'(frame_start), 16'(e.fs));
        chk("underflow",   16'(underflow),   16'(e.uf));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_VD"},   16'(VD), 16'd0);
    chk({tag, "_HSYN"}, 16'(HSYN), 16'd1);
    chk({tag, "_VSYN"}, 16'(VSYN), 16'd1);
    chk({tag, "_rdy"},  16'(pix_ready), 16'd0);
    chk({tag, "_ls"},   16'(line_start), 16'd0);
    chk({tag, "_fs"},   16'(frame_start), 16'd0);
    chk({tag, "_uf"},   16'(underflow), 16'd0);
  endtask

  task automatic cfg_min();
    hsw = 0; hds = 0; hdw = 1; hde = 0; vsw = 0; vds = 0; vdw = 1; vcr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, k;
    for (int i = 0; i < 4096; i++) pix[i] = 9'($urandom);
    reset_N = 0; pix_en = 1; pix_valid = 1; pix_data = 9'h1ff;
    cfg_min();
    model_reset();

    // reset / idle
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk); pix_en = 0; reset_N = 1;
    repeat (3) step(0, 1);

    // minimal frame, two frames of back-to-back pixels
    s0 = src;
    repeat (480) step(1, 1);
    chk("consumed_2frames", 16'(src - s0), 16'd64);

    // underflow on dots 20-21 of frame line 3
    s0 = src;
    for (int i = 0; i < 240; i++) step(1, !(my == 3 && (mx == 20 || mx == 21)));
    chk("consumed_underflow_frame", 16'(src - s0), 16'd30);

    // pix_en throttled to every third clk
    s0 = src;
    for (int i = 0; i < 720; i++) step(i % 3 == 0, 1);
    chk("consumed_throttled", 16'(src - s0), 16'd32);

    // hdw change mid-HACTIVE
    k = 0;
    while (!(my == 3 && mx == 20) && k < 1000) begin step(1, 1); k++; end
    chk("reach_hactive", 16'(my == 3 && mx == 20), 16'd1);
    hdw = 3;
    repeat (500) step(1, 1);
    // vdw change mid-frame
    k = 0;
    while (my != 2 && k < 2000) begin step(1, 1); k++; end
    chk("reach_line2", 16'(my), 16'd2);
    vdw = 3;
    repeat (1500) step(1, 1);

    // randomized traffic with occasional config changes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0) begin
        hsw = 5'($urandom_range(2)); hds = 7'($urandom_range(2));
        hdw = 7'($urandom_range(3)); hde = 7'($urandom_range(2));
        vsw = 5'($urandom_range(1)); vds = 8'($urandom_range(1));
        vdw = 9'($urandom_range(3)); vcr = 8'($urandom_range(1));
      end
      step($urandom_range(9) < 7, $urandom_range(19) < 17);
    end

    // mid-frame reset while vertically active
    k = 0;
    while (!m_vact() && k < 3000) begin step(1, 1); k++; end
    chk("reach_vactive", 16'(m_vact()), 16'd1);
    repeat (5) step(1, 1);
    @(posedge clk); #2;
    reset_N = 0;
    #1 chk_reset_vals("midrst");
    model_reset();
    @(negedge clk); pix_en = 0; reset_N = 1;
    cfg_min();
    repeat (480) step(1, $urandom_range(9) < 9);

    k = 0;
    while (sb.size() > 0 && k < 10) begin @(posedge clk); #2; k++; end
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vdc_pixel_tx.md
# vdc_pixel_tx

Video-side transmitter for the VCE pixel interface. Generates programmable HuC6270-style horizontal and vertical timing, emits active-low HSYN/VSYN, and streams 9-bit palette indices on VD from an upstream pixel source via a ready/valid handshake. VD = 0 outside the active window, so the VCE blanks it. Sits between the VDC sprite/background compositor and the VCE.

## Interface

- No parameters.
- clk  in  1  master clock.
- reset_N  in  1  asynchronous, active-low reset.
- pix_en  in  1  dot-clock enable; all timing advances only on clk edges with pix_en=1.
- hsw  in  5  horizontal sync width, (hsw+1)*8 dots.
- hds  in  7  horizontal back porch, (hds+1)*8 dots.
- hdw  in  7  horizontal active, (hdw+1)*8 dots.
- hde  in  7  horizontal front porch, (hde+1)*8 dots.
- vsw  in  5  vertical sync width, vsw+1 lines.
- vds  in  8  vertical back porch, vds+2 lines.
- vdw  in  9  vertical active, vdw+1 lines.
- vcr  in  8  vertical front porch, vcr+1 lines.
- pix_data  in  9  palette index from compositor.
- pix_valid  in  1  pix_data valid.
- pix_ready  out  1  combinational: pix_en & current position in H-active & V-active.
- VD  out  9  registered pixel index to VCE.
- HSYN  out  1  registered horizontal sync, active low.
- VSYN  out  1  registered vertical sync, active low.
- line_start  out  1  one-cycle pulse, registered, on first dot of each HSYNC.
- frame_start  out  1  one-cycle pulse, registered, on first dot of frame (line 0 of VSYNC).
- underflow  out  1  one-cycle pulse: active dot with pix_valid=0.

## Operation

- Position counters: dot (3 b, within 8-dot tile), tile (7 b, within H region), line (9 b, within V region).
- H FSM: HSYNC -> HBACK -> HACTIVE -> HFRONT -> HSYNC. Each region lasts (len+1) tiles; transition when dot=7 and tile=len. Line length = 8*(hsw+hds+hdw+hde+4) dots.
- V FSM advances once per line, at the HFRONT->HSYNC transition: VSYNC (vsw+1) -> VBACK (vds+2) -> VACTIVE (vdw+1) -> VFRONT (vcr+1) -> VSYNC.
- Config sampling: hsw/hds/hdw/hde are captured into shadow registers on entry to HSYNC; vsw/vds/vdw/vcr on entry to frame line 0. Mid-line/mid-frame changes have no effect until the next capture point.
- Per pix_en edge, the registered outputs reflect the current position:
  - HSYN = ~(H==HSYNC).
  - VSYN = ~(V==VSYNC).
  - VD: if in active and pix_valid, VD <= pix_data (transfer). If in active and !pix_valid, VD <= 0 and underflow pulses. Else VD <= 0.
- Transfer occurs iff pix_ready & pix_valid in the same clk; exactly one pixel is consumed per active dot.
- With pix_en=0: outputs hold, pulses (line_start, frame_start, underflow) deassert, pix_ready=0.

## Timing

- Reset (async, immediate): H=HSYNC, V=VSYNC, all counters 0, shadow registers 0. Outputs: VD=0, HSYN=1, VSYN=1, line_start=0, frame_start=0, underflow=0, pix_ready=0.
- First pix_en edge after reset release: HSYN=0, VSYN=0, line_start=1, frame_start=1; config is captured on this edge.
- Output latency: one pix_en edge from position to VD/sync outputs.
- Data latency: pix_data -> VD is one clk on the transfer edge.
- Wrap: at the end of VFRONT's last line, frame_start pulses at the next HSYNC dot 0. Counters never exceed their region length.
- A reset asserted mid-frame aborts immediately. Timing restarts at frame line 0 and no partial-line output occurs.

## Test plan

- Reset/idle: hold reset_N=0, toggle clk -> VD=0, HSYN=VSYN=1, pix_ready=0; release with pix_en=0 -> outputs unchanged.
- Minimal frame: hsw=hds=hde=0, hdw=1, vsw=vds=vcr=0, vdw=1, pix_en=1, pix_valid=1 with an incrementing pix_data -> 40-dot lines (HSYN low 8 dots, VD nonzero 16 dots starting at dot 16), and 6-line frames (VSYN low line 0, active lines 3–4). frame_start every 240 clks, 32 pixels consumed per frame in order.
- Underflow: same config, pix_valid=0 for dots 20–21 of an active line -> VD=0 and underflow=1 on those two outputs, no pixel consumed, the following pixel resumes in order.
- pix_en throttle: pix_en=1 every 3rd clk -> identical dot sequence, with each output held 3 clks and no duplicate consumption.
- Shadowing: change hdw 1->3 mid-HACTIVE -> the current line stays 40 dots and the next line is 56 dots. Change vdw mid-frame -> takes effect the following frame.
- Mid-frame reset: assert reset_N=0 during VACTIVE -> outputs immediately go to reset values. After release, the first pix_en edge gives frame_start=1.
